// File: rtl/hazard_ctrl_sb_if.sv
// ID-stage hazard control bus: decoded ID fields in, pipeline enables and stall stats out.
interface hazard_ctrl_sb_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic              pc_load;
  logic              if_id_load;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              busy_state;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, opcode, rs1, rs2, rd,
    input  pc_load, if_id_load, if_id_flush, id_ex_bubble, busy_state, stall_count
  );

  modport slave (
    input  id_valid, opcode, rs1, rs2, rd,
    output pc_load, if_id_load, if_id_flush, id_ex_bubble, busy_state, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_sb.sv
// ID hazard unit with in-flight rd scoreboard, branch-wait FSM and saturating stall counter.
// Outputs are combinational from ID fields and state; scoreboard sees an issue one cycle later.
// Stalls front end on RAW hazards and for BRANCH_LAT cycles after control flow; HAZARD_FWD_EN limits stalls to load-use.
module hazard_ctrl_sb #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int BRANCH_LAT = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  hazard_ctrl_sb_if.slave  bus
);
  localparam int CW = (BRANCH_LAT > 0) ? $clog2(BRANCH_LAT + 1) : 1;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic [ADDR_W-1:0] tag;
  } slot_t;

  typedef enum logic {RUN, BR_WAIT} state_t;

  slot_t            slot_q [DEPTH];
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic uses_rs1, uses_rs2, writes_rd, is_load, is_cf;
  logic match_rs1, match_rs2, data_hazard, issue;

  always_comb begin
    uses_rs1  = bus.opcode inside {7'b0110011, 7'b0100011, 7'b1100011,
                                   7'b0000011, 7'b0010011, 7'b1100111};
    uses_rs2  = bus.opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    writes_rd = (bus.opcode inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b1101111,
                                    7'b1100111, 7'b0110111, 7'b0010111}) && (bus.rd != '0);
    is_load   = (bus.opcode == 7'b0000011);
    is_cf     = bus.opcode inside {7'b1100011, 7'b1101111, 7'b1100111};
  end

  always_comb begin
    match_rs1 = 1'b0;
    match_rs2 = 1'b0;
`ifdef HAZARD_FWD_EN
    // Everything but a load still in EX is forwarded.
    match_rs1 = slot_q[0].valid && slot_q[0].is_load && (slot_q[0].tag == bus.rs1);
    match_rs2 = slot_q[0].valid && slot_q[0].is_load && (slot_q[0].tag == bus.rs2);
`else
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_q[k].valid && (slot_q[k].tag == bus.rs1)) match_rs1 = 1'b1;
      if (slot_q[k].valid && (slot_q[k].tag == bus.rs2)) match_rs2 = 1'b1;
    end
`endif
    data_hazard = bus.id_valid &&
                  ((uses_rs1 && (bus.rs1 != '0) && match_rs1) ||
                   (uses_rs2 && (bus.rs2 != '0) && match_rs2));
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    issue            = 1'b0;
    bus.pc_load      = 1'b1;
    bus.if_id_load   = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (data_hazard) begin
          bus.pc_load      = 1'b0;
          bus.if_id_load   = 1'b0;
          bus.id_ex_bubble = 1'b1;
        end else if (bus.id_valid) begin
          issue = 1'b1;
          if (is_cf) begin
            bus.if_id_flush = 1'b1;
            if (BRANCH_LAT > 0) begin
              bus.pc_load = 1'b0;
              state_d     = BR_WAIT;
              cnt_d       = CW'(BRANCH_LAT - 1);
            end
          end
        end
      end
      BR_WAIT: begin
        bus.if_id_load   = 1'b0;
        bus.id_ex_bubble = 1'b1;
        // Final wait cycle: PC captures the resolved target.
        bus.pc_load      = (cnt_q == '0);
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q[0] <= issue ? slot_t'{valid: writes_rd, is_load: is_load, tag: bus.rd} : '0;
      for (int k = 1; k < DEPTH; k++) slot_q[k] <= slot_q[k-1];
      if (!bus.pc_load && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.busy_state  = (state_q == BR_WAIT);
  assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Randomized and directed bench for hazard_ctrl_sb against an instruction-history reference model.
module tb_hazard_ctrl_sb;
  localparam int DEPTH = 3;
  localparam int BLAT  = 2;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hazard_ctrl_sb_if #(.ADDR_W(5), .CNT_W(CNT_W)) bus ();
  hazard_ctrl_sb #(.ADDR_W(5), .DEPTH(DEPTH), .BRANCH_LAT(BLAT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       v;
    bit       ld;
    bit [4:0] tag;
  } ent_t;

  ent_t hist[$];      // what issued in each of the last DEPTH cycles, newest first
  int   wait_left;    // branch-wait cycles still to serve
  int   m_stalls;

  function automatic bit f_u1(bit [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011, 7'b1100111};
  endfunction
  function automatic bit f_u2(bit [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit f_wr(bit [6:0] op, bit [4:0] d);
    return (op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b1101111,
                       7'b1100111, 7'b0110111, 7'b0010111}) && d != 0;
  endfunction
  function automatic bit f_cf(bit [6:0] op);
    return op inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction

  function automatic bit m_match(bit [4:0] r);
    bit m = 0;
`ifdef HAZARD_FWD_EN
    m = hist[0].v && hist[0].ld && hist[0].tag == r;
`else
    foreach (hist[i]) if (hist[i].v && hist[i].tag == r) m = 1;
`endif
    return m;
  endfunction

  task automatic model_out(output bit pc, output bit ld, output bit fl, output bit bub,
                           output bit busy, output bit iss);
    bit haz;
    haz  = bus.id_valid && ((f_u1(bus.opcode) && bus.rs1 != 0 && m_match(bus.rs1)) ||
                            (f_u2(bus.opcode) && bus.rs2 != 0 && m_match(bus.rs2)));
    pc = 1; ld = 1; fl = 0; bub = 0; busy = 0; iss = 0;
    if (wait_left > 0) begin
      busy = 1; ld = 0; bub = 1; pc = (wait_left == 1);
    end else if (haz) begin
      pc = 0; ld = 0; bub = 1;
    end else if (bus.id_valid) begin
      iss = 1;
      if (f_cf(bus.opcode)) begin
        fl = 1; pc = (BLAT == 0);
      end
    end
  endtask

  always @(posedge clock or negedge reset) begin
    bit pc, ld, fl, bub, busy, iss;
    ent_t e;
    if (!reset) begin
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back('{0, 0, 0});
      wait_left = 0;
      m_stalls  = 0;
    end else begin
      model_out(pc, ld, fl, bub, busy, iss);
      e.v   = iss && f_wr(bus.opcode, bus.rd);
      e.ld  = iss && bus.opcode == 7'b0000011;
      e.tag = iss ? bus.rd : 5'd0;
      hist.push_front(e);
      void'(hist.pop_back());
      if (wait_left > 0) wait_left--;
      else if (iss && f_cf(bus.opcode) && BLAT > 0) wait_left = BLAT;
      if (!pc && m_stalls < SAT) m_stalls++;
    end
  end

  always @(negedge clock) begin
    bit pc, ld, fl, bub, busy, iss;
    if (hist.size() == DEPTH) begin
      model_out(pc, ld, fl, bub, busy, iss);
      check("pc_load",      bus.pc_load,      pc);
      check("if_id_load",   bus.if_id_load,   ld);
      check("if_id_flush",  bus.if_id_flush,  fl);
      check("id_ex_bubble", bus.id_ex_bubble, bub);
      check("busy_state",   bus.busy_state,   busy);
      check("stall_count",  bus.stall_count,  m_stalls);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(bit v, bit [6:0] op, bit [4:0] a, bit [4:0] b, bit [4:0] d);
    bus.id_valid = v; bus.opcode = op; bus.rs1 = a; bus.rs2 = b; bus.rd = d;
  endtask

  task automatic next;
    @(posedge clock); #1;
  endtask

  task automatic do_reset;
    @(posedge clock); #2 reset = 1'b0;
    put(0, 0, 0, 0, 0);
    @(posedge clock); #2 reset = 1'b1;
  endtask

  // Returns at the negedge of the cycle in which ID issues; counts stall cycles before it.
  task automatic run_until_issue(output int stalls);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.if_id_load) return;
      stalls++;
      next();
    end
  endtask

  localparam bit [6:0] OP_ADD  = 7'b0110011;
  localparam bit [6:0] OP_ADDI = 7'b0010011;
  localparam bit [6:0] OP_LW   = 7'b0000011;
  localparam bit [6:0] OP_BEQ  = 7'b1100011;

`ifdef HAZARD_FWD_EN
  localparam int RAW_STALLS = 0;
  localparam int LU_STALLS  = 1;
`else
  localparam int RAW_STALLS = 3;
  localparam int LU_STALLS  = 3;
`endif

  bit [6:0] ops [10] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011,
                         7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0000000};

  initial begin
    int s;
    put(0, 0, 0, 0, 0);
    #3;
    check("rst pc_load",      bus.pc_load,      1);
    check("rst if_id_load",   bus.if_id_load,   1);
    check("rst if_id_flush",  bus.if_id_flush,  0);
    check("rst id_ex_bubble", bus.id_ex_bubble, 0);
    check("rst busy_state",   bus.busy_state,   0);
    check("rst stall_count",  bus.stall_count,  0);
    @(posedge clock); #2 reset = 1'b1;

    // back-to-back RAW
    do_reset();
    put(1, OP_ADD, 1, 2, 5); run_until_issue(s); next();
    put(1, OP_ADD, 5, 1, 6); run_until_issue(s);
    check("raw stalls", s, RAW_STALLS);
    check("raw stall_count", bus.stall_count, RAW_STALLS);

    // load-use
    do_reset();
    put(1, OP_LW, 1, 0, 4); run_until_issue(s); next();
    put(1, OP_ADD, 4, 1, 6); run_until_issue(s);
    check("load-use stalls", s, LU_STALLS);

    // x0 immunity and rs2 filter
    do_reset();
    put(1, OP_ADD, 1, 2, 0); run_until_issue(s); next();
    put(1, OP_ADD, 0, 1, 3); run_until_issue(s);
    check("x0 stalls", s, 0);
    next();
    put(1, OP_ADD, 1, 2, 7); run_until_issue(s); next();
    put(1, OP_ADDI, 1, 7, 8); run_until_issue(s);
    check("rs2 filter stalls", s, 0);

    // branch wait
    do_reset();
    put(1, OP_BEQ, 1, 2, 0);
    @(negedge clock);
    check("br issue flush", bus.if_id_flush, 1);
    check("br issue pc_load", bus.pc_load, 0);
    next(); put(0, 0, 0, 0, 0);
    @(negedge clock);
    check("br wait1 busy", bus.busy_state, 1);
    check("br wait1 pc_load", bus.pc_load, 0);
    next(); @(negedge clock);
    check("br wait2 busy", bus.busy_state, 1);
    check("br wait2 pc_load", bus.pc_load, 1);
    next(); @(negedge clock);
    check("br run busy", bus.busy_state, 0);
    check("br stall_count", bus.stall_count, 2);

    // hazard plus branch
    do_reset();
    put(1, OP_LW, 1, 0, 3); run_until_issue(s); next();
    put(1, OP_BEQ, 3, 0, 0); run_until_issue(s);
    check("haz+br stalls", s, LU_STALLS);
    check("haz+br flush", bus.if_id_flush, 1);
    next(); put(0, 0, 0, 0, 0);
    @(negedge clock);
    check("haz+br wait1 busy", bus.busy_state, 1);
    next(); @(negedge clock);
    check("haz+br wait2 pc_load", bus.pc_load, 1);
    check("haz+br stall_count", bus.stall_count, LU_STALLS + 2);

    // reset mid branch wait
    do_reset();
    put(1, OP_ADD, 1, 2, 9); run_until_issue(s); next();
    put(1, OP_BEQ, 1, 2, 0); run_until_issue(s); next();
    put(0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    check("midrst pc_load", bus.pc_load, 1);
    check("midrst busy", bus.busy_state, 0);
    check("midrst stall_count", bus.stall_count, 0);
    @(posedge clock); #2 reset = 1'b1;
    put(1, OP_ADD, 9, 1, 10); run_until_issue(s);
    check("midrst dep stalls", s, 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      next();
      put($urandom_range(0, 9) < 8, ops[$urandom_range(0, 9)],
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 249) == 0) begin
        #1 reset = 1'b0;
        @(posedge clock); #2 reset = 1'b1;
      end
    end
    next();
    put(0, 0, 0, 0, 0);
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
